// File: rtl/neuromorphic_x1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuromorphic_x1_pkg
//  Description : Shared types and widths for the NEUROMORPHIC_X1 functional
//                port initiator (FSM states, command/response records).
//  Revision    : 1.0 - initial release
// ============================================================================
package neuromorphic_x1_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    // Counter width able to hold max_val (at least one bit).
    function automatic int ctr_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuromorphic_x1_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : neuromorphic_x1_initiator_if
//  Description : Command/response channels plus macro request bus of the
//                NEUROMORPHIC_X1 initiator. master = initiator view,
//                slave = fabric/macro view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface neuromorphic_x1_initiator_if;
    import neuromorphic_x1_pkg::*;

    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [SEL_W-1:0]  cmd_sel;
    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // Macro request bus
    logic              EN;
    logic              R_WB;
    logic [ADDR_W-1:0] AD;
    logic [DATA_W-1:0] DI;
    logic [SEL_W-1:0]  SEL;
    logic [DATA_W-1:0] DO;
    logic              func_ack;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_ready, DO, func_ack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, EN, R_WB, AD, DI, SEL
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_ready, DO, func_ack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, EN, R_WB, AD, DI, SEL
    );

endinterface
`default_nettype wire

// File: rtl/neuromorphic_x1_wait_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : neuromorphic_x1_wait_ctr
//  Description : Saturating up-counter with synchronous clear, count enable
//                and a terminal-count flag (count == MAX_VAL).
//  Revision    : 1.0 - initial release
// ============================================================================
module neuromorphic_x1_wait_ctr
    import neuromorphic_x1_pkg::*;
#(
    parameter int MAX_VAL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int              c_WIDTH = ctr_width(MAX_VAL);
    localparam logic [c_WIDTH-1:0] c_MAX = c_WIDTH'(MAX_VAL);

    logic [c_WIDTH-1:0] r_count;

    // Count enabled cycles, stop at MAX_VAL; clear has priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/neuromorphic_x1_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : neuromorphic_x1_initiator
//  Description : Bus initiator for the NEUROMORPHIC_X1 functional port. Takes
//                one read/write command at a time, holds EN and the bus fields
//                until func_ack or timeout, returns a response, then enforces
//                a minimum EN-low gap before the next command.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuromorphic_x1_initiator
    import neuromorphic_x1_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int GAP_CYC = 1
) (
    input  logic                               CLKin,
    input  logic                               RSTin,
    neuromorphic_x1_initiator_if.master        bus,
    output logic                               busy,
    output logic                               stray_ack
);

    // Timeout fires on the TIMEOUT-th ack-less REQ cycle, i.e. when the count
    // of earlier ack-less cycles equals TIMEOUT-1.
    localparam bit c_TIMEOUT_EN = (TIMEOUT != 0);
    localparam int c_WAIT_MAX   = (TIMEOUT > 1) ? TIMEOUT - 1 : 0;
    // The next command can only be sampled one edge after cmd_ready rises, so
    // leaving for IDLE needs EN low for GAP_CYC-1 cycles; the gap counter is
    // one behind the EN-low cycle count, hence GAP_CYC-2.
    localparam int c_GAP_MAX    = (GAP_CYC > 2) ? GAP_CYC - 2 : 0;

    state_t             r_state;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_en;
    logic               r_rwb;
    logic [ADDR_W-1:0]  r_ad;
    logic [DATA_W-1:0]  r_di;
    logic [SEL_W-1:0]   r_sel;
    logic               r_rsp_valid;
    rsp_t               r_rsp;
    logic               r_stray;

    cmd_t               w_cmd;
    logic               w_cmd_hs;
    logic               w_rsp_hs;
    logic               w_wait_tc;
    logic               w_gap_tc;

    assign w_cmd    = '{we: bus.cmd_we, addr: bus.cmd_addr, wdata: bus.cmd_wdata, sel: bus.cmd_sel};
    assign w_cmd_hs = bus.cmd_valid & r_cmd_ready;
    assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;

    neuromorphic_x1_wait_ctr #(.MAX_VAL(c_WAIT_MAX)) u_timeout_ctr (
        .clk   (CLKin),
        .rst   (RSTin),
        .i_clr (w_cmd_hs),
        .i_en  ((r_state == REQ) & ~bus.func_ack),
        .o_tc  (w_wait_tc)
    );

    // Counts EN-low cycles; held at zero while a request is on the bus.
    neuromorphic_x1_wait_ctr #(.MAX_VAL(c_GAP_MAX)) u_gap_ctr (
        .clk   (CLKin),
        .rst   (RSTin),
        .i_clr (r_en),
        .i_en  (~r_en),
        .o_tc  (w_gap_tc)
    );

    // Transaction FSM with all outputs registered.
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_en        <= 1'b0;
            r_rwb       <= 1'b0;
            r_ad        <= '0;
            r_di        <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_hs) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_en        <= 1'b1;
                        r_rwb       <= ~w_cmd.we;
                        r_ad        <= w_cmd.addr;
                        r_di        <= w_cmd.wdata;
                        r_sel       <= w_cmd.sel;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    // An ack in the timeout cycle still completes normally.
                    if (bus.func_ack) begin
                        r_en        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp.rdata <= r_rwb ? bus.DO : {DATA_W{1'b0}};
                        r_rsp.err   <= 1'b0;
                        r_state     <= RESP;
                    end else if (c_TIMEOUT_EN && w_wait_tc) begin
                        r_en        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp.rdata <= {DATA_W{1'b0}};
                        r_rsp.err   <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        if (w_gap_tc) begin
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_state     <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (w_gap_tc) begin
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky flag for any acknowledge arriving with no request on the bus.
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            r_stray <= 1'b0;
        end else if (bus.func_ack && !r_en) begin
            r_stray <= 1'b1;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp.rdata;
    assign bus.rsp_err   = r_rsp.err;
    assign bus.EN        = r_en;
    assign bus.R_WB      = r_rwb;
    assign bus.AD        = r_ad;
    assign bus.DI        = r_di;
    assign bus.SEL       = r_sel;
    assign busy          = r_busy;
    assign stray_ack     = r_stray;

endmodule
`default_nettype wire

// File: tb/tb_neuromorphic_x1_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuromorphic_x1_initiator
//  Description : Directed self-checking bench for neuromorphic_x1_initiator
//                (TIMEOUT=8, GAP_CYC=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuromorphic_x1_initiator;
    import neuromorphic_x1_pkg::*;

    localparam int TIMEOUT = 8;
    localparam int GAP_CYC = 3;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic stray_ack;
    int   n_checks = 0;
    int   n_errors = 0;

    neuromorphic_x1_initiator_if bus ();

    neuromorphic_x1_initiator #(.TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
        .CLKin     (clk),
        .RSTin     (rst),
        .bus       (bus),
        .busy      (busy),
        .stray_ack (stray_ack)
    );

    always #5 clk = ~clk;

    // Every DUT output in one vector for all-zero reset checks.
    function automatic logic [106:0] all_outs();
        return {bus.cmd_ready, bus.rsp_valid, bus.EN, bus.R_WB, bus.AD, bus.DI, bus.SEL,
                busy, stray_ack, bus.rsp_rdata, bus.rsp_err};
    endfunction

    task automatic drive_idle();
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.cmd_sel = '0; bus.rsp_ready = 1'b0; bus.DO = '0; bus.func_ack = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel);
        int n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = addr;
        bus.cmd_wdata = wdata; bus.cmd_sel = sel;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL wait_idle: busy=%b required 0 within 50 cycles", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; drive_idle();
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outs() !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, busy, bus.EN} !== 3'b100) begin
            n_errors++; $display("FAIL reset_release: cmd_ready/busy/EN=%b required 100",
                                 {bus.cmd_ready, busy, bus.EN});
        end
    endtask

    task automatic test_read();
        send_cmd(1'b0, 32'h10, 32'hA5A5_A5A5, 4'hF);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.EN, bus.R_WB, bus.rsp_valid, bus.AD} !== {3'b110, 32'h10}) begin
                n_errors++; $display("FAIL read_req[%0d]: EN/R_WB/rsp_valid=%b AD=%h required 110 AD=10",
                                     i, {bus.EN, bus.R_WB, bus.rsp_valid}, bus.AD);
            end
            if (i == 2) begin bus.func_ack = 1'b1; bus.DO = 32'hDEAD_BEEF; end
            @(negedge clk);
        end
        bus.func_ack = 1'b0; bus.DO = '0;
        n_checks++;
        if ({bus.EN, bus.R_WB, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {4'b0110, 32'hDEAD_BEEF}) begin
            n_errors++; $display("FAIL read_rsp: EN/R_WB/valid/err=%b rdata=%h required 0110 DEADBEEF",
                                 {bus.EN, bus.R_WB, bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL read_rsp_drop: rsp_valid=%b required 0", bus.rsp_valid);
        end
        wait_idle();
    endtask

    task automatic test_write();
        send_cmd(1'b1, 32'h04, 32'h1234_5678, 4'hF);
        bus.func_ack = 1'b1; bus.DO = 32'hCAFE_F00D;
        n_checks++;
        if ({bus.EN, bus.R_WB, bus.rsp_valid, bus.AD, bus.DI, bus.SEL} !== {3'b100, 32'h04, 32'h1234_5678, 4'hF}) begin
            n_errors++; $display("FAIL write_req: EN/R_WB/valid=%b AD=%h DI=%h SEL=%h required 100 04 12345678 F",
                                 {bus.EN, bus.R_WB, bus.rsp_valid}, bus.AD, bus.DI, bus.SEL);
        end
        @(negedge clk);
        bus.func_ack = 1'b0;
        n_checks++;
        if ({bus.EN, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b010, 32'h0}) begin
            n_errors++; $display("FAIL write_rsp: EN/valid/err=%b rdata=%h required 010 0",
                                 {bus.EN, bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata);
        end
        n_checks++;
        if ({bus.R_WB, bus.AD, bus.DI, bus.SEL} !== {1'b0, 32'h04, 32'h1234_5678, 4'hF}) begin
            n_errors++; $display("FAIL write_retain: R_WB=%b AD=%h DI=%h SEL=%h required 0 04 12345678 F",
                                 bus.R_WB, bus.AD, bus.DI, bus.SEL);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        wait_idle();
    endtask

    task automatic test_timeout();
        n_checks++;
        if (stray_ack !== 1'b0) begin
            n_errors++; $display("FAIL stray_before: stray_ack=%b required 0", stray_ack);
        end
        bus.DO = 32'hFFFF_FFFF;
        send_cmd(1'b0, 32'h40, 32'h0, 4'h3);
        for (int i = 0; i < TIMEOUT; i++) begin
            n_checks++;
            if ({bus.EN, bus.rsp_valid} !== 2'b10) begin
                n_errors++; $display("FAIL timeout_wait[%0d]: EN/rsp_valid=%b required 10", i, {bus.EN, bus.rsp_valid});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({bus.EN, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b011, 32'h0}) begin
            n_errors++; $display("FAIL timeout_rsp: EN/valid/err=%b rdata=%h required 011 0",
                                 {bus.EN, bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.func_ack  = 1'b1;
        @(negedge clk);
        bus.func_ack  = 1'b0;
        bus.DO        = '0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({stray_ack, bus.rsp_valid, bus.EN} !== 3'b100) begin
                n_errors++; $display("FAIL late_ack[%0d]: stray/rsp_valid/EN=%b required 100",
                                     i, {stray_ack, bus.rsp_valid, bus.EN});
            end
            @(negedge clk);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int n = 0;
        send_cmd(1'b0, 32'h20, 32'h0, 4'h1);
        bus.func_ack = 1'b1; bus.DO = 32'h55AA_55AA;
        @(negedge clk);
        bus.func_ack = 1'b0; bus.DO = '0;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 32'h30;
        bus.cmd_wdata = 32'h0BAD_F00D; bus.cmd_sel = 4'hC;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.EN, bus.rsp_rdata} !== {4'b1000, 32'h55AA_55AA}) begin
                n_errors++; $display("FAIL backpressure[%0d]: valid/err/cmd_ready/EN=%b rdata=%h required 1000 55AA55AA",
                                     i, {bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.EN}, bus.rsp_rdata);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.EN} !== 2'b00) begin
            n_errors++; $display("FAIL bp_release: rsp_valid/EN=%b required 00", {bus.rsp_valid, bus.EN});
        end
        while (bus.cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_checks++;
        if ({bus.EN, bus.R_WB, bus.AD, bus.DI, bus.SEL} !== {2'b10, 32'h30, 32'h0BAD_F00D, 4'hC}) begin
            n_errors++; $display("FAIL bp_next_cmd: EN/R_WB=%b AD=%h DI=%h SEL=%h required 10 30 0BADF00D C",
                                 {bus.EN, bus.R_WB}, bus.AD, bus.DI, bus.SEL);
        end
        bus.func_ack = 1'b1;
        @(negedge clk);
        bus.func_ack = 1'b0;
        bus.rsp_ready = 1'b1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'h0}) begin
            n_errors++; $display("FAIL bp_next_rsp: valid/err=%b rdata=%h required 10 0",
                                 {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  t_we    = 4'b1010;   // bit k = we of command k
        logic [31:0] t_addr  [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        logic [31:0] t_wdata [4] = '{32'h0, 32'h1111_2222, 32'h0, 32'h3333_4444};
        logic [31:0] t_do    [4] = '{32'h0A0A_0A0A, 32'h7777_7777, 32'h0B0B_0B0B, 32'h8888_8888};
        logic [31:0] t_exp   [4] = '{32'h0A0A_0A0A, 32'h0, 32'h0B0B_0B0B, 32'h0};
        int   issued = 0;
        int   got = 0;
        int   low_run = 0;
        int   cyc = 0;
        bit   seen_req = 1'b0;
        logic prev_en = 1'b0;
        bus.rsp_ready = 1'b1;
        while (got < 4 && cyc < 200) begin
            if (bus.EN === 1'b1) begin
                if (!prev_en && seen_req) begin
                    n_checks++;
                    if (low_run < GAP_CYC) begin
                        n_errors++; $display("FAIL b2b_gap: EN low %0d cycles required >= %0d", low_run, GAP_CYC);
                    end
                end
                seen_req = 1'b1; low_run = 0;
            end else begin
                low_run++;
            end
            prev_en = bus.EN;
            if (bus.rsp_valid === 1'b1) begin
                n_checks++;
                if ({bus.rsp_err, bus.cmd_ready, bus.rsp_rdata} !== {2'b00, t_exp[got]}) begin
                    n_errors++; $display("FAIL b2b_rsp[%0d]: err/cmd_ready=%b rdata=%h required 00 %h",
                                         got, {bus.rsp_err, bus.cmd_ready}, bus.rsp_rdata, t_exp[got]);
                end
                got++;
            end
            bus.func_ack = bus.EN;
            bus.DO = (issued > 0) ? t_do[issued-1] : 32'h0;
            if (issued < 4) begin
                bus.cmd_valid = 1'b1; bus.cmd_we = t_we[issued]; bus.cmd_addr = t_addr[issued];
                bus.cmd_wdata = t_wdata[issued]; bus.cmd_sel = 4'hF;
                if (bus.cmd_ready === 1'b1) issued++;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0; bus.func_ack = 1'b0; bus.rsp_ready = 1'b0;
        n_checks++;
        if (got != 4 || issued != 4) begin
            n_errors++; $display("FAIL b2b_count: issued=%0d responses=%0d required 4 4", issued, got);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        send_cmd(1'b0, 32'h50, 32'h0, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_errors++; $display("FAIL async_reset: outputs %h required 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, bus.rsp_valid, stray_ack, busy, bus.EN} !== 5'b10000) begin
            n_errors++; $display("FAIL reset_after: cmd_ready/rsp_valid/stray/busy/EN=%b required 10000",
                                 {bus.cmd_ready, bus.rsp_valid, stray_ack, busy, bus.EN});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.rsp_valid, bus.EN} !== 2'b00) begin
                n_errors++; $display("FAIL reset_quiet[%0d]: rsp_valid/EN=%b required 00", i, {bus.rsp_valid, bus.EN});
            end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
